// File: rtl/lcd_pkg.sv
// Shared HD44780 bus definitions: command opcodes, DDRAM address constants,
// responder states and DDRAM address helpers.
package lcd_pkg;

    localparam logic [7:0] CMD_CLR       = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_END  = 7'h27;
    localparam logic [6:0] LINE2_END  = 7'h67;

    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_UNINIT,
        ST_IDLE,
        ST_BUSY,
        ST_CLEARING
    } lcd_state_t;

    // Only the first 16 columns of each line are backed by the 2x16 buffer.
    function automatic logic addr_visible(input logic [6:0] a);
        return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
    endfunction

    function automatic logic [4:0] addr_index(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == LINE1_END) return LINE2_BASE;
            if (a == LINE2_END) return LINE1_BASE;
            return a + 7'd1;
        end
        if (a == LINE1_BASE) return LINE2_END;
        if (a == LINE2_BASE) return LINE1_END;
        return a - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 display buffer: one write port, a combinational bus-side read port
// and a registered read port for panel mirroring.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [4:0] wa,
    input  logic [7:0] wd,
    input  logic [4:0] bus_ra,
    output logic [7:0] bus_rd,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char
);

    logic [7:0] mem [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) mem[i] <= SPACE;
            rd_char <= SPACE;
        end else begin
            if (we) mem[wa] <= wd;
            rd_char <= mem[rd_addr];
        end
    end

    assign bus_rd = mem[bus_ra];

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible responder: synchronizes the parallel LCD bus, decodes
// commands/data into the display buffer and models busy timing.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int CMD_BUSY  = 37,
    parameter int LONG_BUSY = 1520,
    parameter int INIT_SETS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic       initialized,
    output logic       display_on,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       err_pulse
);

    localparam int CW = $clog2(LONG_BUSY);
    localparam int SW = $clog2(INIT_SETS + 1);

    logic [1:0]  en_sy, rs_sy, rw_sy;
    logic [15:0] data_sy;
    logic        en_s, rs_s, rw_s, en_d, commit;
    logic [7:0]  data_s;
    logic        cap_rs, cap_rw;
    logic [7:0]  cap_data;

    lcd_state_t  state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [4:0]  clr_idx, clr_nx;
    logic [6:0]  addr, addr_nx;
    logic        id, id_nx, two_line, two_nx;
    logic [SW-1:0] set_cnt, set_nx;
    logic        init_nx, disp_nx, cmdv_nx, err_nx;
    logic [7:0]  code_nx;

    logic        we;
    logic [4:0]  wa;
    logic [7:0]  wd, bus_rd;

    assign en_s   = en_sy[1];
    assign rs_s   = rs_sy[1];
    assign rw_s   = rw_sy[1];
    assign data_s = data_sy[15:8];
    assign commit = en_d & ~en_s;
    assign busy   = (state == ST_BUSY) || (state == ST_CLEARING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sy <= '0; rs_sy <= '0; rw_sy <= '0; data_sy <= '0; en_d <= 1'b0;
            cap_rs <= 1'b0; cap_rw <= 1'b0; cap_data <= '0;
        end else begin
            en_sy   <= {en_sy[0], lcd_en};
            rs_sy   <= {rs_sy[0], lcd_rs};
            rw_sy   <= {rw_sy[0], lcd_rw};
            data_sy <= {data_sy[7:0], lcd_data_in};
            en_d    <= en_s;
            if (en_s) begin
                cap_rs   <= rs_s;
                cap_rw   <= rw_s;
                cap_data <= data_s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_UNINIT; cnt <= '0; clr_idx <= '0; addr <= '0; id <= 1'b1;
            two_line <= 1'b0; set_cnt <= '0; initialized <= 1'b0; display_on <= 1'b0;
            cmd_valid <= 1'b0; cmd_code <= '0; err_pulse <= 1'b0;
            lcd_data_oe <= 1'b0; lcd_data_out <= '0;
        end else begin
            state <= state_nx; cnt <= cnt_nx; clr_idx <= clr_nx; addr <= addr_nx; id <= id_nx;
            two_line <= two_nx; set_cnt <= set_nx; initialized <= init_nx; display_on <= disp_nx;
            cmd_valid <= cmdv_nx; cmd_code <= code_nx; err_pulse <= err_nx;
            lcd_data_oe  <= en_s & rw_s & (~rs_s | ~busy);
            lcd_data_out <= rs_s ? (addr_visible(addr) ? bus_rd : SPACE) : {busy, addr};
        end
    end

    always_comb begin
        state_nx = state; cnt_nx = cnt; clr_nx = clr_idx; addr_nx = addr; id_nx = id;
        two_nx = two_line; set_nx = set_cnt; init_nx = initialized; disp_nx = display_on;
        code_nx = cmd_code; cmdv_nx = 1'b0; err_nx = 1'b0;
        we = 1'b0; wa = addr_index(addr); wd = cap_data;

        if (busy) begin
            // LONG_BUSY >= 32 guarantees the fill finishes before the count expires.
            if (state == ST_CLEARING) begin
                we = 1'b1; wa = clr_idx; wd = SPACE;
                clr_nx = clr_idx + 5'd1;
                if (clr_idx == 5'd31) state_nx = ST_BUSY;
            end
            if (cnt == '0) state_nx = ST_IDLE;
            else           cnt_nx = cnt - 1'b1;
        end

        if (commit) begin
            if (cap_rw) begin
                if (cap_rs) begin
                    if (busy) err_nx = 1'b1;
                    else      addr_nx = addr_step(addr, id);
                end
            end else if (busy) begin
                err_nx = 1'b1;
            end else if (state == ST_UNINIT) begin
                if (!cap_rs && cap_data[7:5] == 3'b001) begin
                    two_nx = cap_data[3]; cmdv_nx = 1'b1; code_nx = cap_data;
                    set_nx = set_cnt + 1'b1;
                    if (set_cnt == SW'(INIT_SETS - 1)) begin
                        init_nx = 1'b1; state_nx = ST_BUSY; cnt_nx = CW'(CMD_BUSY - 1);
                    end
                end else begin
                    err_nx = 1'b1;
                end
            end else begin
                state_nx = ST_BUSY; cnt_nx = CW'(CMD_BUSY - 1);
                if (cap_rs) begin
                    we = addr_visible(addr);
                    addr_nx = addr_step(addr, id);
                end else begin
                    cmdv_nx = 1'b1; code_nx = cap_data;
                    casez (cap_data)
                        8'b1???????: addr_nx = cap_data[6:0];
                        8'b01??????: ;
                        8'b001?????: two_nx = cap_data[3];
                        8'b0001????: if (!cap_data[3]) addr_nx = addr_step(addr, cap_data[2]);
                        8'b00001???: disp_nx = cap_data[2];
                        8'b000001??: id_nx = cap_data[1];
                        8'b0000001?: begin
                            addr_nx = LINE1_BASE; cnt_nx = CW'(LONG_BUSY - 1);
                        end
                        8'b00000001: begin
                            addr_nx = LINE1_BASE; id_nx = 1'b1; clr_nx = '0;
                            state_nx = ST_CLEARING; cnt_nx = CW'(LONG_BUSY - 1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    lcd_ddram u_ddram (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .bus_ra  (addr_index(addr)),
        .bus_rd  (bus_rd),
        .rd_addr (rd_addr),
        .rd_char (rd_char)
    );

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: drives the LCD bus like the display
// driver and checks buffer, address, busy timing and error reporting.
module tb_lcd_bus_responder;

    localparam int CMD_BUSY  = 37;
    localparam int LONG_BUSY = 1520;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data_in = '0;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe, busy, initialized, display_on, cmd_valid, err_pulse;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_char, cmd_code;

    int checks = 0, failures = 0;
    int err_cnt = 0, cmdv_cnt = 0, busy_cyc = 0;

    lcd_bus_responder #(.CMD_BUSY(CMD_BUSY), .LONG_BUSY(LONG_BUSY), .INIT_SETS(3)) dut (
        .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
        .busy(busy), .initialized(initialized), .display_on(display_on),
        .rd_addr(rd_addr), .rd_char(rd_char), .cmd_valid(cmd_valid),
        .cmd_code(cmd_code), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (err_pulse) err_cnt++;
        if (cmd_valid) cmdv_cnt++;
        if (busy)      busy_cyc++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d, input int gap);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_en = 1'b1;
        repeat (6) @(negedge clk);
        lcd_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] v, output logic oe);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
        repeat (5) @(negedge clk);
        v = lcd_data_out; oe = lcd_data_oe;
        lcd_en = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic char_at(input logic [4:0] idx, output logic [7:0] v);
        @(negedge clk);
        rd_addr = idx;
        @(negedge clk);
        v = rd_char;
    endtask

    task automatic count_non_space(output int bad);
        logic [7:0] v;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            char_at(5'(i), v);
            if (v !== 8'h20) bad++;
        end
    endtask

    task automatic wait_busy(input logic level, input int limit, input string tag);
        int n;
        n = 0;
        while (busy !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(busy), 32'(level));
    endtask

    initial begin
        logic [7:0] v, press [7], line2 [6];
        logic       oe;
        int         e0, bad;
        press = '{8'h50, 8'h52, 8'h45, 8'h53, 8'h53, 8'h20, 8'h23};
        line2 = '{8'h52, 8'h3A, 8'h31, 8'h32, 8'h33, 8'h34};

        repeat (3) @(negedge clk);
        check_val("rst_init", 32'(initialized), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_disp", 32'(display_on), 0);
        check_val("rst_oe", 32'(lcd_data_oe), 0);
        check_val("rst_dout", 32'(lcd_data_out), 0);
        check_val("rst_code", 32'(cmd_code), 0);
        check_val("rst_rdchar", 32'(rd_char), 32'h20);
        rst = 1'b0;

        // Init sequence with a premature data write
        bus_write(0, 8'h38, 10);
        bus_write(0, 8'h38, 10);
        e0 = err_cnt;
        bus_write(1, 8'h41, 10);
        check_val("uninit_err", 32'(err_cnt - e0), 1);
        char_at(0, v);
        check_val("uninit_buf", 32'(v), 32'h20);
        check_val("uninit_flag", 32'(initialized), 0);
        bus_write(0, 8'h38, 45);
        check_val("init_flag", 32'(initialized), 1);
        check_val("init_cmds", 32'(cmdv_cnt), 3);
        check_val("init_idle", 32'(busy), 0);

        bus_write(0, 8'h0C, 45);
        check_val("disp_on", 32'(display_on), 1);
        check_val("cmd_code", 32'(cmd_code), 32'h0C);

        // Line 1
        bus_write(0, 8'h01, LONG_BUSY + 10);
        bus_write(0, 8'h80, 45);
        for (int i = 0; i < 7; i++) bus_write(1, press[i], 45);
        for (int i = 0; i < 7; i++) begin
            char_at(5'(i), v);
            check_val($sformatf("line1_%0d", i), 32'(v), 32'(press[i]));
        end
        bus_read(0, v, oe);
        check_val("stat_oe", 32'(oe), 1);
        check_val("stat_addr7", 32'(v), 32'h07);
        check_val("oe_drop", 32'(lcd_data_oe), 0);

        // Line 2 and wrap from 0x27 into line 2
        bus_write(0, 8'hC0, 45);
        for (int i = 0; i < 6; i++) bus_write(1, line2[i], 45);
        for (int i = 0; i < 6; i++) begin
            char_at(5'(16 + i), v);
            check_val($sformatf("line2_%0d", i), 32'(v), 32'(line2[i]));
        end
        bus_write(0, 8'hA7, 45);
        bus_write(1, 8'h58, 45);
        bus_read(0, v, oe);
        check_val("wrap_addr", 32'(v), 32'h40);
        char_at(7, v);
        check_val("hidden_drop", 32'(v), 32'h20);
        bus_write(1, 8'h59, 45);
        char_at(16, v);
        check_val("wrap_Y", 32'(v), 32'h59);

        // Busy handling: dropped write does not extend busy
        busy_cyc = 0;
        e0 = err_cnt;
        bus_write(1, 8'h61, 10);
        bus_write(1, 8'h62, 0);
        bus_read(0, v, oe);
        check_val("stat_busy", 32'(v), 32'hC2);
        repeat (45) @(negedge clk);
        check_val("busy_drop_err", 32'(err_cnt - e0), 1);
        check_val("cmd_busy_len", 32'(busy_cyc), CMD_BUSY);
        bus_read(0, v, oe);
        check_val("stat_idle", 32'(v), 32'h42);
        char_at(17, v);
        check_val("busy_first", 32'(v), 32'h61);
        char_at(18, v);
        check_val("busy_second", 32'(v), 32'h31);

        // Data reads: accepted when idle, rejected when busy
        bus_read(1, v, oe);
        check_val("dread_oe", 32'(oe), 1);
        check_val("dread_val", 32'(v), 32'h31);
        e0 = err_cnt;
        bus_write(1, 8'h63, 2);
        bus_read(1, v, oe);
        check_val("dread_busy_oe", 32'(oe), 0);
        repeat (45) @(negedge clk);
        check_val("dread_busy_err", 32'(err_cnt - e0), 1);
        bus_read(0, v, oe);
        check_val("dread_addr", 32'(v), 32'h44);

        // Decrement wrap and cursor shift wrap
        bus_write(0, 8'h04, 45);
        bus_write(0, 8'h80, 45);
        bus_write(1, 8'h41, 45);
        bus_read(0, v, oe);
        check_val("dec_wrap", 32'(v), 32'h67);
        char_at(0, v);
        check_val("dec_A", 32'(v), 32'h41);
        bus_write(0, 8'h14, 45);
        bus_read(0, v, oe);
        check_val("shift_wrap", 32'(v), 32'h00);

        // Clear
        busy_cyc = 0;
        bus_write(0, 8'h01, 0);
        wait_busy(1, 20, "clr_busy_rise");
        repeat (33) @(negedge clk);
        count_non_space(bad);
        check_val("clr_fill", 32'(bad), 0);
        check_val("clr_still_busy", 32'(busy), 1);
        wait_busy(0, 2000, "clr_busy_fall");
        check_val("long_busy_len", 32'(busy_cyc), LONG_BUSY);
        bus_write(1, 8'h5A, 45);
        bus_read(0, v, oe);
        check_val("clr_id_inc", 32'(v), 32'h01);

        // Reset mid-clear
        bus_write(0, 8'hC4, 45);
        bus_write(1, 8'h51, 45);
        char_at(20, v);
        check_val("pre_rst_Q", 32'(v), 32'h51);
        bus_write(0, 8'h01, 0);
        wait_busy(1, 20, "rclr_busy_rise");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("mid_rst_busy", 32'(busy), 0);
        check_val("mid_rst_init", 32'(initialized), 0);
        check_val("mid_rst_disp", 32'(display_on), 0);
        check_val("mid_rst_code", 32'(cmd_code), 0);
        rst = 1'b0;
        count_non_space(bad);
        check_val("mid_rst_fill", 32'(bad), 0);
        e0 = err_cnt;
        bus_write(1, 8'h4B, 10);
        check_val("mid_rst_uninit", 32'(err_cnt - e0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Synthesizable HD44780-compatible responder for the 8-bit parallel LCD bus (`lcd_data`, `lcd_en`, `lcd_rs`, `lcd_rw`) that the safe's display driver writes.
- Decodes commands and character writes into a 2×16 display buffer.
- Models busy timing and answers busy-flag/address and data reads.
- Lets the safe mirror the panel contents (debug readout, second display) and serves as the checking end of the LCD link in system benches.

## Interface
Parameters:
- `CMD_BUSY`, 37: busy cycles after any command or data write except clear/home.
- `LONG_BUSY`, 1520: busy cycles after clear or return-home; must be ≥ 32.
- `INIT_SETS`, 3: function-set writes required before leaving UNINIT.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `lcd_en`  in  1  bus enable strobe; transaction latched on its falling edge.
- `lcd_rs`  in  1  0 = command/status, 1 = data.
- `lcd_rw`  in  1  0 = write, 1 = read.
- `lcd_data_in`  in  8  bus data from the driver.
- `lcd_data_out`  out  8  read data.
- `lcd_data_oe`  out  1  drive enable for `lcd_data_out`.
- `busy`  out  1  internal busy flag.
- `initialized`  out  1  set once INIT_SETS function sets have been seen.
- `display_on`  out  1  D bit of the last display-control command.
- `rd_addr`  in  5  buffer index: 0–15 is line 1, 16–31 is line 2.
- `rd_char`  out  8  character at `rd_addr`, registered.
- `cmd_valid`  out  1  one-cycle pulse per accepted command (rs=0, rw=0).
- `cmd_code`  out  8  last accepted command byte.
- `err_pulse`  out  1  one-cycle pulse when a write is dropped (busy, or UNINIT and not a function set).

## Operation
- **Input synchronization:** `lcd_en`, `lcd_rs`, `lcd_rw` and `lcd_data_in` pass through 2-flop synchronizers. rs/rw/data are captured every cycle while synced en = 1. A falling edge (en_d = 1, en = 0) commits the captured transaction.
- **FSM:**
  - UNINIT: only function set (`data[7:5]` = 001) is accepted; it increments set_cnt. When set_cnt reaches INIT_SETS, go to BUSY and then IDLE, and set `initialized`.
  - IDLE: accept any transaction.
  - BUSY: the counter runs down to 0, then go to IDLE. Writes arriving in BUSY are dropped, raise `err_pulse`, and do not restart the counter.
  - CLEARING: a sub-phase of BUSY. clr_idx writes 0x20 to entries 0..31, one per cycle.
- **Command decode** (rs=0, rw=0, highest set bit wins):
  - 1aaaaaaa: `addr` = aaaaaaa.
  - 01xxxxxx: CGRAM address; ignored apart from busy.
  - 001DNFxx: store N as two_line.
  - 0001SRxx: if S = 0, move cursor right (R=1) or left; otherwise no effect.
  - 00001DCB: `display_on` = D.
  - 000001IS: id = I.
  - 0000001x: `addr` = 0, LONG_BUSY.
  - 00000001: `addr` = 0, id = 1, start CLEARING, LONG_BUSY.
  - 00000000: no-op, CMD_BUSY.
- **Address map:** 7-bit DDRAM `addr`. Range 0x00–0x0F maps to index `addr`; range 0x40–0x4F maps to index `addr` − 0x30. Other addresses are non-visible: writes to them are discarded and reads return 0x20.
- **Increment (id=1):** 0x27 → 0x40, 0x67 → 0x00, otherwise +1.
- **Decrement (id=0):** 0x00 → 0x67, 0x40 → 0x27, otherwise −1.
- **Data write (rs=1, rw=0):** store at the mapped index if visible, then step `addr`, then CMD_BUSY.
- **Status read (rs=0, rw=1):** while synced en = 1, `lcd_data_oe` = 1 and `lcd_data_out` = {`busy`, `addr`}. Allowed in any state and never dropped.
- **Data read (rs=1, rw=1):** `lcd_data_out` = char at `addr`. On the falling edge, step `addr`. Rejected while busy: `oe` = 0 and `err_pulse` is raised.
- **Simultaneous events:** when the clear counter and a `rd_addr` read hit the same entry, the read returns the pre-clear value. A falling edge coinciding with the busy counter reaching 0 counts as busy.
- **Reset values:**
  - Buffer all 0x20, `addr` 0, id 1, two_line 0, set_cnt 0, state UNINIT.
  - All outputs 0, except `rd_char`, which is 0x20.
  - Reset mid-CLEARING aborts the clear and applies the reset fill.

## Timing
- Bus edge to commit: 3 `clk` (2 sync + edge detect).
- The buffer, `addr`, `cmd_valid`/`cmd_code` and `err_pulse` update on the cycle after commit.
- `busy` rises on that same cycle and stays high for exactly CMD_BUSY or LONG_BUSY cycles.
- CLEARING completes in 32 cycles from busy rise.
- `lcd_data_oe`/`lcd_data_out` become valid 3 cycles after en rises and drop 3 cycles after en falls.
- `rd_char` latency: 1 cycle.
- The driver must hold en high for ≥ 4 `clk` cycles; shorter pulses are undefined.

## Structure
- Shared package `lcd_pkg`, used by both this block and the display driver:
  - command masks/opcodes (CLR 0x01, HOME 0x02, SET_DDRAM 0x80);
  - line base addresses 0x00/0x40 and wrap constants 0x27/0x67;
  - SPACE 0x20;
  - responder state encoding.
- One sub-module, `lcd_ddram`: 32×8 buffer with one write port and two read ports (bus-side and `rd_addr`), reset-filled with 0x20.

## Test plan
- **Init:** reset, then three 0x38 writes → `initialized` = 1. A 0x41 data write before the third set → `err_pulse`, buffer unchanged.
- **Line writes:** after init, 0x01 then 0x80 then "PRESS #" → `rd_char`[0..6] = 0x50,0x52,0x45,0x53,0x53,0x20,0x23; `addr` reads back 0x07.
- **Line 2 and wrap:** 0xC0, "R:1234" → indices 16–21 hold "R:1234". Set `addr` 0x27, write 'X' → discarded, `addr` = 0x40. Then write 'Y' → index 16 = 'Y'.
- **Busy handling:** write a char, then a second write 10 cycles later (CMD_BUSY = 37) → second write dropped with `err_pulse`. Status read during busy returns bit7 = 1; read after 37 cycles returns bit7 = 0.
- **Decrement and clear:** 0x04 entry mode, 0x80, write 'A' → `addr` = 0x67. Then 0x01 → after 32 cycles all entries = 0x20, `addr` 0, id 1, `busy` high for 1520 cycles.
- **Reset mid-clear:** `rst` asserted 10 cycles into a clear → state UNINIT, all outputs reset, buffer all 0x20.
